rsc_encoder: RTL
================

Name: rsc_encoder

Overview:
- 8-state recursive systematic convolutional encoder. It is the transmit-side counterpart of the MAP decoder datapath.
- Accepts one information bit per handshake and emits systematic and parity bits, then terminates the trellis with 3 tail steps.
- Each output is also BPSK-mapped to a 12-bit two's-complement soft value that feeds the decoder's input1/input2 loading path in loopback tests.

Parameters:
- BLOCK_LEN, 6144: information bits per block; legal range 1..8191.
- AMP, 256: magnitude of the BPSK soft value. Bit 0 maps to +AMP, bit 1 maps to -AMP.
- CNT_W, 13: width of the bit counter.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- start  input  1  one-cycle pulse; begins a block when idle
- in_bit  input  1  information bit
- in_valid  input  1  in_bit is valid
- in_ready  output  1  encoder accepts in_bit this cycle
- out_valid  output  1  output registers hold a valid symbol
- out_ready  input  1  downstream consumes the symbol
- sys_bit  output  1  systematic bit (u; tail input during termination)
- par_bit  output  1  parity bit
- sys_out  output  12  BPSK-mapped sys_bit
- par_out  output  12  BPSK-mapped par_bit
- out_tail  output  1  current symbol is a termination symbol
- out_last  output  1  final symbol of the block (third tail)
- busy  output  1  high from start acceptance until the last symbol is consumed
- done  output  1  one-cycle pulse when the last symbol is consumed

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Clock port is clock, reset port is reset_n. reset_n is sampled only on the rising edge of clock.
- Reset: FSM goes to IDLE and the trellis state S={s1,s2,s3} is cleared to 000. Counter = 0. Outputs at reset:
  - in_ready, out_valid, busy, done, out_tail, out_last, sys_bit, par_bit = 0.
  - sys_out, par_out = 0.
- Reset mid-block aborts the block immediately. No done pulse is generated and partial output is discarded.
- Trellis (generators g0=13 octal feedback, g1=15 octal), with s1 the newest state bit:
  - a = u ^ s2 ^ s3
  - p = a ^ s1 ^ s3
  - next S = {a, s1, s2}
- Termination: u = s2 ^ s3, which forces a = 0. sys_bit = u and p is computed as above. After 3 tail steps S = 000.
- FSM:
  - IDLE: start moves to ENC; counter = 0 and S = 000. start is ignored in any other state.
  - ENC: in_ready = !out_valid | out_ready. When in_valid & in_ready:
    - register sys_bit=in_bit, par_bit=p, out_valid=1;
    - update S and increment the counter;
    - when the counter reaches BLOCK_LEN-1, go to TAIL with tail counter = 0.
  - TAIL: in_ready = 0. Whenever the output slot is free (!out_valid | out_ready), emit one tail symbol with out_tail=1 and update S. The third tail symbol carries out_last=1; then go to FLUSH.
  - FLUSH: wait until out_valid & out_ready on the last symbol. Then pulse done for 1 cycle, clear busy and return to IDLE.
- Output slot: single register stage. out_valid is cleared on consume when no new symbol is loaded in the same cycle. Consume and load in the same cycle is allowed and gives full throughput (1 symbol/cycle).
- Holding: while out_valid & !out_ready, all output fields hold stable and S does not advance.
- Latency: 1 cycle from input acceptance to out_valid.
- Block size: a block produces exactly BLOCK_LEN+3 symbols.
- Mapping: sys_out = bit ? -AMP : +AMP, as 12-bit two's complement (AMP=256 gives 12'h100 or 12'hF00). par_out is mapped the same way.
- Boundaries:
  - in_valid with no start (IDLE) is ignored, and in_ready stays 0.
  - BLOCK_LEN=1 goes to TAIL after the first accepted bit.

Test Plan:
- BLOCK_LEN=4, input 1,0,0,0, out_ready=1 -> sys 1,0,0,0 then tail sys 1,0,1. par 1,1,1,1 then 1,1,1. S=110 before termination and 000 after. done pulses once after 7 symbols.
- BLOCK_LEN=4, all-zero input -> all 7 symbols have sys=par=0. sys_out=par_out=12'h100. out_tail high on symbols 5-7 only. out_last high on symbol 7 only.
- Backpressure: hold out_ready=0 for 5 cycles mid-block -> in_ready=0 and outputs stable throughout. Result bit-identical to the unstalled run with no loss or duplication.
- Full throughput: in_valid=out_ready=1 continuously, BLOCK_LEN=16 -> 19 symbols on 19 consecutive cycles. busy deasserts the cycle after done.
- Reset mid-block: assert reset_n=0 after 2 symbols -> next cycle out_valid=0, busy=0, S=000, no done. A following start/block encodes correctly from state 0.
- start while busy is ignored. in_valid in IDLE is not accepted, and in_ready stays 0.

Source files
------------

// File: rtl/rsc_encoder.sv
// 8-state recursive systematic convolutional encoder (g0=13 feedback, g1=15 octal)
// with 3-step trellis termination and BPSK soft-value mapping of both output bits.
module rsc_encoder #(
  parameter int BLOCK_LEN = 6144,
  parameter int AMP       = 256,
  parameter int CNT_W     = 13
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_bit,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sys_bit,
  output logic        par_bit,
  output logic [11:0] sys_out,
  output logic [11:0] par_out,
  output logic        out_tail,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, ENC, TAIL, FLUSH} state_t;

  localparam logic [11:0]      POS_AMP  = 12'(AMP);
  localparam logic [11:0]      NEG_AMP  = 12'(-AMP);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [2:0]       r_trellis;
  logic [CNT_W-1:0] r_bitCnt;
  logic [1:0]       r_tailCnt;
  logic             r_outValid;
  logic             r_sysBit;
  logic             r_parBit;
  logic [11:0]      r_sysOut;
  logic [11:0]      r_parOut;
  logic             r_outTail;
  logic             r_outLast;
  logic             r_busy;
  logic             r_done;

  logic w_s1, w_s2, w_s3;
  logic w_slotFree, w_accept, w_tailLoad, w_load, w_consume;
  logic w_u, w_a, w_p, w_lastBit, w_lastTail;

  // r_trellis is {s1,s2,s3}; s1 holds the newest feedback bit
  assign w_s1 = r_trellis[2];
  assign w_s2 = r_trellis[1];
  assign w_s3 = r_trellis[0];

  assign w_slotFree = !r_outValid || out_ready;
  assign w_consume  = r_outValid && out_ready;
  assign w_accept   = (r_state == ENC) && in_valid && w_slotFree;
  assign w_tailLoad = (r_state == TAIL) && w_slotFree;
  assign w_load     = w_accept || w_tailLoad;
  assign w_lastBit  = (r_bitCnt == LAST_IDX);
  assign w_lastTail = (r_tailCnt == 2'd2);

  // Tail input cancels the feedback so the register drains to zero
  assign w_u = (r_state == TAIL) ? (w_s2 ^ w_s3) : in_bit;
  assign w_a = w_u ^ w_s2 ^ w_s3;
  assign w_p = w_a ^ w_s1 ^ w_s3;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = ENC;
      ENC:     if (w_accept && w_lastBit) w_nextState = TAIL;
      TAIL:    if (w_tailLoad && w_lastTail) w_nextState = FLUSH;
      FLUSH:   if (w_consume) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_trellis  <= 3'b000;
      r_bitCnt   <= '0;
      r_tailCnt  <= 2'd0;
      r_outValid <= 1'b0;
      r_sysBit   <= 1'b0;
      r_parBit   <= 1'b0;
      r_sysOut   <= 12'd0;
      r_parOut   <= 12'd0;
      r_outTail  <= 1'b0;
      r_outLast  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == FLUSH) && w_consume;

      // busy stays up through the done cycle and drops on the following one
      if (r_state == IDLE && start) begin
        r_busy    <= 1'b1;
        r_trellis <= 3'b000;
        r_bitCnt  <= '0;
        r_tailCnt <= 2'd0;
      end else if (r_done) begin
        r_busy <= 1'b0;
      end

      if (w_load) begin
        r_outValid <= 1'b1;
        r_sysBit   <= w_u;
        r_parBit   <= w_p;
        r_sysOut   <= w_u ? NEG_AMP : POS_AMP;
        r_parOut   <= w_p ? NEG_AMP : POS_AMP;
        r_outTail  <= w_tailLoad;
        r_outLast  <= w_tailLoad && w_lastTail;
        r_trellis  <= {w_a, w_s1, w_s2};
      end else if (w_consume) begin
        r_outValid <= 1'b0;
      end

      if (w_accept) begin
        r_bitCnt <= r_bitCnt + CNT_W'(1);
        if (w_lastBit) r_tailCnt <= 2'd0;
      end

      if (w_tailLoad) begin
        r_tailCnt <= r_tailCnt + 2'd1;
      end
    end
  end

  assign in_ready  = (r_state == ENC) && w_slotFree;
  assign out_valid = r_outValid;
  assign sys_bit   = r_sysBit;
  assign par_bit   = r_parBit;
  assign sys_out   = r_sysOut;
  assign par_out   = r_parOut;
  assign out_tail  = r_outTail;
  assign out_last  = r_outLast;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
